// File: rtl/config_pkg.sv
// Shared types and constants for the CHIP-8 configuration menu.
package config_pkg;

  typedef enum logic [2:0] {
    ITEM_GAME   = 3'd0,
    ITEM_PROC   = 3'd1,
    ITEM_BG     = 3'd2,
    ITEM_FG     = 3'd3,
    ITEM_TIMBRE = 3'd4,
    ITEM_PITCH  = 3'd5,
    ITEM_VOL    = 3'd6,
    ITEM_SPEED  = 3'd7
  } menu_item_e;

  localparam int MENU_ITEMS = 8;

  localparam int PTR_W    = 3;
  localparam int GAME_W   = 4;
  localparam int CIDX_W   = 4;
  localparam int COLOR_W  = 24;
  localparam int TIMBRE_W = 2;
  localparam int VOL_W    = 3;
  localparam int SPEED_W  = 3;

  // RGB888 palette: black, white, primaries, secondaries, then darker tones.
  localparam logic [COLOR_W-1:0] PALETTE [16] = '{
    24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
    24'h808080, 24'h800000, 24'h008000, 24'h000080,
    24'h808000, 24'h008080, 24'h800080, 24'hC0C0C0
  };

  // Step v by one within 0..n-1, wrapping at both ends.
  function automatic logic [3:0] wrap_step(input logic [3:0] v, input logic inc, input int n);
    if (inc) return (int'(v) == n - 1) ? 4'd0 : v + 4'd1;
    else     return (v == 4'd0) ? 4'(n - 1) : v - 4'd1;
  endfunction

  // Step v by one within 0..n-1, holding at both ends.
  function automatic logic [3:0] sat_step(input logic [3:0] v, input logic inc, input int n);
    if (inc) return (int'(v) >= n - 1) ? v : v + 4'd1;
    else     return (v == 4'd0) ? v : v - 4'd1;
  endfunction

endpackage

// File: rtl/chip8_tick_gen.sv
// Instruction-rate pulse generator: one pulse every `period` enabled cycles.
module chip8_tick_gen #(
  parameter int PW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clear,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] cnt;

  // Count 0..period-1; pulse on wrap. Clear or disable restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear || !enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == period - PW'(1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + PW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/config_menu.sv
// CHIP-8 configuration menu: key events edit settings held in registers,
// and the selected speed drives the instruction tick.
module config_menu
  import config_pkg::*;
#(
  parameter int NUM_GAMES          = 16,
  parameter int NUM_COLORS         = 8,
  parameter int NUM_TIMBRES        = 4,
  parameter int VOL_LEVELS         = 8,
  parameter int NUM_SPEEDS         = 4,
  parameter int DEFAULT_SPEED      = 1,
  parameter int BASE_DIV           = 100000,
  parameter int LOCK_WHILE_RUNNING = 1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                key_up_in,
  input  logic                key_down_in,
  input  logic                key_left_in,
  input  logic                key_right_in,
  input  logic                key_select_in,
  output logic [PTR_W-1:0]    ptr_index_out,
  output logic                active_processor_out,
  output logic [GAME_W-1:0]   game_out,
  output logic                load_game_out,
  output logic [COLOR_W-1:0]  bg_color_out,
  output logic [COLOR_W-1:0]  fg_color_out,
  output logic [TIMBRE_W-1:0] timbre_out,
  output logic                pitch_out,
  output logic [VOL_W-1:0]    vol_out,
  output logic [SPEED_W-1:0]  speed_out,
  output logic                chip8_tick_out
);

  localparam int PW = $clog2(BASE_DIV * NUM_SPEEDS + 1);

  if (NUM_GAMES < 2 || NUM_GAMES > 16) begin : g_bad_games
    $error("NUM_GAMES out of range 2..16");
  end
  if (NUM_COLORS < 2 || NUM_COLORS > 16) begin : g_bad_colors
    $error("NUM_COLORS out of range 2..16");
  end
  if (NUM_TIMBRES < 1 || NUM_TIMBRES > 4) begin : g_bad_timbres
    $error("NUM_TIMBRES out of range 1..4");
  end
  if (VOL_LEVELS < 2 || VOL_LEVELS > 8) begin : g_bad_vol
    $error("VOL_LEVELS out of range 2..8");
  end
  if (NUM_SPEEDS < 1 || NUM_SPEEDS > 8) begin : g_bad_speeds
    $error("NUM_SPEEDS out of range 1..8");
  end
  if (DEFAULT_SPEED < 0 || DEFAULT_SPEED >= NUM_SPEEDS) begin : g_bad_dflt
    $error("DEFAULT_SPEED must be below NUM_SPEEDS");
  end
  if (BASE_DIV < 2) begin : g_bad_div
    $error("BASE_DIV must be at least 2");
  end

  logic [CIDX_W-1:0] bg_idx, fg_idx;

  logic [PTR_W-1:0]    ptr_n;
  logic                active_n, load_n, pitch_n;
  logic [GAME_W-1:0]   game_n;
  logic [CIDX_W-1:0]   bg_n, fg_n;
  logic [TIMBRE_W-1:0] timbre_n;
  logic [VOL_W-1:0]    vol_n;
  logic [SPEED_W-1:0]  speed_n;

  // Left has priority over right, so a left event always steps downward.
  logic inc;
  assign inc = ~key_left_in;

  // Colour step skips over the other colour's index so bg and fg never match.
  logic [CIDX_W-1:0] bg_step, fg_step, bg_skip, fg_skip;
  assign bg_step = wrap_step(bg_idx, inc, NUM_COLORS);
  assign fg_step = wrap_step(fg_idx, inc, NUM_COLORS);
  assign bg_skip = (bg_step == fg_idx) ? wrap_step(bg_step, inc, NUM_COLORS) : bg_step;
  assign fg_skip = (fg_step == bg_idx) ? wrap_step(fg_step, inc, NUM_COLORS) : fg_step;

  logic game_locked;
  assign game_locked = (LOCK_WHILE_RUNNING != 0) && active_processor_out;

  // Next-state decode: one event per cycle, select > up > down > left > right.
  always_comb begin
    ptr_n    = ptr_index_out;
    active_n = active_processor_out;
    load_n   = 1'b0;
    game_n   = game_out;
    bg_n     = bg_idx;
    fg_n     = fg_idx;
    timbre_n = timbre_out;
    pitch_n  = pitch_out;
    vol_n    = vol_out;
    speed_n  = speed_out;
    if (key_select_in) begin
      if (ptr_index_out == ITEM_GAME) begin
        load_n   = ~load_game_out;
        active_n = 1'b1;
      end else if (ptr_index_out == ITEM_PROC) begin
        active_n = ~active_processor_out;
      end
    end else if (key_up_in) begin
      ptr_n = ptr_index_out - PTR_W'(1);
    end else if (key_down_in) begin
      ptr_n = ptr_index_out + PTR_W'(1);
    end else if (key_left_in || key_right_in) begin
      case (ptr_index_out)
        ITEM_GAME:   if (!game_locked) game_n = wrap_step(game_out, inc, NUM_GAMES);
        ITEM_BG:     bg_n = bg_skip;
        ITEM_FG:     fg_n = fg_skip;
        ITEM_TIMBRE: timbre_n = TIMBRE_W'(wrap_step({2'b00, timbre_out}, inc, NUM_TIMBRES));
        ITEM_PITCH:  pitch_n = ~pitch_out;
        ITEM_VOL:    vol_n = VOL_W'(sat_step({1'b0, vol_out}, inc, VOL_LEVELS));
        ITEM_SPEED:  speed_n = SPEED_W'(sat_step({1'b0, speed_out}, inc, NUM_SPEEDS));
        default: ;
      endcase
    end
  end

  // Settings registers; colour outputs are looked up alongside their index.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_index_out        <= '0;
      active_processor_out <= 1'b0;
      load_game_out        <= 1'b0;
      game_out             <= '0;
      bg_idx               <= CIDX_W'(0);
      fg_idx               <= CIDX_W'(1);
      bg_color_out         <= PALETTE[0];
      fg_color_out         <= PALETTE[1];
      timbre_out           <= '0;
      pitch_out            <= 1'b0;
      vol_out              <= VOL_W'(VOL_LEVELS / 2);
      speed_out            <= SPEED_W'(DEFAULT_SPEED);
    end else begin
      ptr_index_out        <= ptr_n;
      active_processor_out <= active_n;
      load_game_out        <= load_n;
      game_out             <= game_n;
      bg_idx               <= bg_n;
      fg_idx               <= fg_n;
      bg_color_out         <= PALETTE[bg_n];
      fg_color_out         <= PALETTE[fg_n];
      timbre_out           <= timbre_n;
      pitch_out            <= pitch_n;
      vol_out              <= vol_n;
      speed_out            <= speed_n;
    end
  end

  // The tick counter follows the next active state so pausing never lets a
  // final pulse out, and restarts on a speed change or on start of running.
  logic          tick_clear;
  logic [PW-1:0] period;
  assign tick_clear = (speed_n != speed_out) || (active_n && !active_processor_out);
  assign period     = PW'(BASE_DIV * (NUM_SPEEDS - int'(speed_out)));

  chip8_tick_gen #(.PW(PW)) u_tick (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .enable (active_n),
    .clear  (tick_clear),
    .period (period),
    .tick   (chip8_tick_out)
  );

endmodule

// File: tb/tb_config_menu.sv
// Bench for config_menu: directed test-plan sequence with literal checks,
// then randomized key traffic compared every cycle against a menu model.
module tb_config_menu;

  localparam int NG = 16, NC = 8, NT = 4, NV = 8, NS = 4, BD = 4, DS = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic up = 0, dn = 0, lf = 0, rt = 0, sel = 0;
  logic [2:0]  ptr;
  logic        act, load, pitch, tick;
  logic [3:0]  game;
  logic [23:0] bgc, fgc;
  logic [1:0]  timbre;
  logic [2:0]  vol, speed;

  always #5 clk = ~clk;

  config_menu #(
    .NUM_GAMES(NG), .NUM_COLORS(NC), .NUM_TIMBRES(NT), .VOL_LEVELS(NV),
    .NUM_SPEEDS(NS), .DEFAULT_SPEED(DS), .BASE_DIV(BD), .LOCK_WHILE_RUNNING(1)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .key_up_in(up), .key_down_in(dn), .key_left_in(lf), .key_right_in(rt),
    .key_select_in(sel),
    .ptr_index_out(ptr), .active_processor_out(act), .game_out(game),
    .load_game_out(load), .bg_color_out(bgc), .fg_color_out(fgc),
    .timbre_out(timbre), .pitch_out(pitch), .vol_out(vol), .speed_out(speed),
    .chip8_tick_out(tick)
  );

  logic [23:0] pal [8] = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
                           24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};

  int m_ptr, m_act, m_game, m_load, m_bg, m_fg, m_tim, m_pitch, m_vol, m_spd, m_tick, m_phase;
  int n_cmp = 0, n_err = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_ptr = 0; m_act = 0; m_game = 0; m_load = 0; m_bg = 0; m_fg = 1;
    m_tim = 0; m_pitch = 0; m_vol = NV / 2; m_spd = DS; m_tick = 0; m_phase = 0;
  endfunction

  function automatic int wrapi(input int v, input int d, input int n);
    return (v + d + n) % n;
  endfunction

  function automatic int clampi(input int v, input int n);
    return (v < 0) ? 0 : (v > n - 1) ? n - 1 : v;
  endfunction

  // Menu rules applied to the model for one clock edge.
  function automatic void m_step(input bit s, input bit u, input bit d, input bit l, input bit r);
    int old_act, old_spd, dir, prev_load;
    old_act = m_act; old_spd = m_spd; prev_load = m_load;
    m_load = 0;
    if (s) begin
      if (m_ptr == 0) begin
        m_load = (prev_load == 0) ? 1 : 0;
        m_act = 1;
      end else if (m_ptr == 1) m_act = 1 - m_act;
    end else if (u) m_ptr = (m_ptr + 7) % 8;
    else if (d) m_ptr = (m_ptr + 1) % 8;
    else if (l || r) begin
      dir = l ? -1 : 1;
      case (m_ptr)
        0: if (m_act == 0) m_game = wrapi(m_game, dir, NG);
        2: begin m_bg = wrapi(m_bg, dir, NC); if (m_bg == m_fg) m_bg = wrapi(m_bg, dir, NC); end
        3: begin m_fg = wrapi(m_fg, dir, NC); if (m_fg == m_bg) m_fg = wrapi(m_fg, dir, NC); end
        4: m_tim = wrapi(m_tim, dir, NT);
        5: m_pitch = 1 - m_pitch;
        6: m_vol = clampi(m_vol + dir, NV);
        7: m_spd = clampi(m_spd + dir, NS);
        default: ;
      endcase
    end
    if (m_spd != old_spd || (m_act == 1 && old_act == 0) || m_act == 0) begin
      m_phase = 0; m_tick = 0;
    end else begin
      m_phase++;
      m_tick = (m_phase == BD * (NS - m_spd)) ? 1 : 0;
      if (m_tick == 1) m_phase = 0;
    end
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ptr", int'(ptr), m_ptr);
      check("active", int'(act), m_act);
      check("game", int'(game), m_game);
      check("load_game", int'(load), m_load);
      check("bg_color", int'(bgc), int'(pal[m_bg]));
      check("fg_color", int'(fgc), int'(pal[m_fg]));
      check("timbre", int'(timbre), m_tim);
      check("pitch", int'(pitch), m_pitch);
      check("vol", int'(vol), m_vol);
      check("speed", int'(speed), m_spd);
      check("tick", int'(tick), m_tick);
    end
  end

  task automatic step(input bit s, input bit u, input bit d, input bit l, input bit r);
    @(negedge clk);
    rst_n = 1'b1;
    sel = s; up = u; dn = d; lf = l; rt = r;
    @(posedge clk);
    m_step(s, u, d, l, r);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic reset_step();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    sel = 0; up = 0; dn = 0; lf = 0; rt = 0;
    m_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ticks, first;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ptr", int'(ptr), 0);
    check("rst_game", int'(game), 0);
    check("rst_bg", int'(bgc), 24'h000000);
    check("rst_fg", int'(fgc), 24'hFFFFFF);
    check("rst_vol", int'(vol), 4);
    check("rst_speed", int'(speed), 1);
    check("rst_active", int'(act), 0);
    check("rst_tick", int'(tick), 0);
    chk_en = 1;

    step(0, 1, 0, 0, 0);              check("up_wrap", int'(ptr), 7);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
    check("down8", int'(ptr), 7);
    step(0, 1, 1, 0, 1);              check("prio_ptr", int'(ptr), 6);
    check("prio_speed", int'(speed), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);              check("bg_skip", int'(bgc), 24'hFF0000);
    step(0, 0, 0, 1, 0);              check("bg_back", int'(bgc), 24'h000000);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);              check("fg_skip", int'(fgc), 24'hFF00FF);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    check("vol_sat", int'(vol), 7);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);              check("speed_sat", int'(speed), 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);              check("game_wrap_dn", int'(game), 15);
    step(0, 0, 0, 0, 1);              check("game_wrap_up", int'(game), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);              check("load_pulse", int'(load), 1);
    check("sel_active", int'(act), 1);
    step(1, 0, 0, 0, 0);              check("load_not_back2back", int'(load), 0);
    step(0, 0, 0, 0, 1);              check("game_locked", int'(game), 3);

    // Tick period at speed 3 with BASE_DIV 4 is 4 cycles.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    ticks = 0;
    for (int i = 0; i < 16; i++) begin step(0, 0, 0, 0, 0); ticks += int'(tick); end
    check("ticks_speed3", ticks, 4);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    first = -1;
    for (int i = 1; i <= 40 && first < 0; i++) begin
      step(0, 0, 0, 0, 0);
      if (tick) first = i;
    end
    check("first_tick_speed0", first, 16);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);              check("paused", int'(act), 0);
    ticks = 0;
    for (int i = 0; i < 40; i++) begin step(0, 0, 0, 0, 0); ticks += int'(tick); end
    check("ticks_paused", ticks, 0);

    // Randomized key traffic with occasional mid-run resets.
    reset_step();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) reset_step();
      else step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0);
    end
    idle(2);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
